filt_stim_seq: RTL and testbench
================================

// Module: filt_stim_seq
// PURPOSE
// Sequences a test run of the GSPS pulse-shaping filter. Flushes the delay line, drives one
// stimulus stream (impulse, zero-stuffed 4-ASK PRBS or DC step) at sample rate, then drains.
// Tracks peak |y| for the run. Sits between clk_en/GSPS_filt and the lab control logic.
// PARAMETERS
// WIDTH        18       sample width, x_out and y_in, signed 1s17
// LENGTH       93       filter taps; number of samples in FLUSH and in DRAIN
// NSAMP        1024     stimulus samples in RUN, >=1
// CNTW         11       width of the sample counter, must hold max(LENGTH,NSAMP)
// MAP_A        16384    4-ASK unit level a; levels are -3a,-a,+a,+3a
// IMPULSE_AMP  131071   impulse height, mode 1
// PORTS
// sys_clk      in   1      system clock
// rst          in   1      synchronous active-high reset
// sam_clk_en   in   1      sample strobe, one sys_clk wide
// sym_clk_en   in   1      symbol strobe, one sys_clk wide, coincident with a sam_clk_en
// start        in   1      run request pulse, honoured only in IDLE
// abort        in   1      cancel current run
// mode         in   2      0 zeros, 1 impulse, 2 4-ASK PRBS, 3 DC step; latched on start
// y_in         in   WIDTH  filter output, signed
// x_out        out  WIDTH  filter input, signed, registered
// busy         out  1      high in FLUSH, RUN and DRAIN
// done         out  1      one-cycle pulse when a run completes normally
// peak_abs     out  WIDTH  max |y_in| over RUN+DRAIN, unsigned magnitude
// BEHAVIOUR
// - Reset: state IDLE, x_out=0, busy=0, done=0, peak_abs=0, cnt=0, lfsr=9'h1FF.
// - FSM: IDLE -start-> FLUSH -LENGTH samples-> RUN -NSAMP samples-> DRAIN -LENGTH samples->
//   DONE -1 cycle-> IDLE.
// - Only sam_clk_en cycles count samples. cnt clears on each state entry.
// - Transition on the enable that completes the count, so the next enable is the new state's first.
// - start in IDLE: latch mode, clear peak_abs, load lfsr=9'h1FF, enter FLUSH next cycle.
// - start outside IDLE is ignored.
// - x_out updates only on sam_clk_en and otherwise holds. FLUSH and DRAIN drive 0.
// - RUN mode 0: x_out=0.
// - RUN mode 1: IMPULSE_AMP on RUN sample 0, then 0.
// - RUN mode 2: on sam_clk_en with sym_clk_en, x_out = map(lfsr[1:0]); on other samples x_out=0
//   (zero-stuffed). Map: 00->-3a, 01->-a, 10->+a, 11->+3a.
// - RUN mode 2 LFSR: x^9+x^5+1 Fibonacci, new bit = lfsr[8]^lfsr[4], shifted into bit 0.
//   Advances once per symbol, after the current symbol is mapped. Only symbols in RUN advance it.
// - RUN mode 3: x_out=3*MAP_A on every RUN sample.
// - Peak: on sam_clk_en in RUN or DRAIN, m=|y_in|, and peak_abs=max(peak_abs,m).
//   |y_in| of -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1. peak_abs holds after done until next start.
// - done: high for exactly the DONE cycle. busy is low in DONE and IDLE.
// - abort: in any state except IDLE, go to IDLE next cycle with x_out=0 and no done pulse.
//   peak_abs keeps its partial value. abort has priority over start and over count completion.
// - rst mid-run: same as power-on reset values, overriding everything.
// - Latency: start to first FLUSH sample is the first sam_clk_en at least 1 cycle after start.
//   done occurs LENGTH+NSAMP+LENGTH sample strobes after FLUSH entry, plus 1 cycle.
// TESTING
// - Mode 1, NSAMP=100, sam_clk_en every 4 cycles -> x_out=0 for 93 samples, then 131071 once,
//   then 0.
// - Mode 1 count check -> busy high for exactly 286 strobes; done one cycle after the 286th.
// - Mode 2, sym_clk_en every 4th sam_clk_en, seed 1FF -> first RUN symbol +49152 (bits 11).
//   Mode 2 stuffing -> the 3 following samples are 0.
// - Mode 2 sequence -> the symbol sequence matches the x^9+x^5+1 reference model for 256 symbols.
// - Mode 3 -> x_out=49152 on all RUN samples.
// - Peak: y_in=-131072 during RUN -> peak_abs=131071.
// - Peak: y_in=+20000 during FLUSH -> not captured.
// - Abort in RUN -> IDLE next cycle, x_out=0, done never pulses.
// - Start during DRAIN -> ignored, run completes normally.
// - rst asserted mid-DRAIN -> all outputs 0 next cycle.
// - Start after rst -> LFSR restarts from 1FF.

Source files
------------

// File: rtl/filt_stim_seq.sv
// Stimulus sequencer for the pulse-shaping filter: flush, drive one stream, drain.
// Also tracks the peak filter output magnitude over the run.
module filt_stim_seq #(
    parameter int WIDTH       = 18,
    parameter int LENGTH      = 93,
    parameter int NSAMP       = 1024,
    parameter int CNTW        = 11,
    parameter int MAP_A       = 16384,
    parameter int IMPULSE_AMP = 131071
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    sam_clk_en,
    input  logic                    sym_clk_en,
    input  logic                    start,
    input  logic                    abort,
    input  logic [1:0]              mode,
    input  logic signed [WIDTH-1:0] y_in,
    output logic signed [WIDTH-1:0] x_out,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        peak_abs
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [CNTW-1:0] LEN_M1 = CNTW'(LENGTH - 1);
    localparam logic [CNTW-1:0] NS_M1  = CNTW'(NSAMP - 1);
    localparam logic signed [WIDTH-1:0] A1  = WIDTH'(MAP_A);
    localparam logic signed [WIDTH-1:0] A3  = WIDTH'(3 * MAP_A);
    localparam logic signed [WIDTH-1:0] IMP = WIDTH'(IMPULSE_AMP);
    localparam logic signed [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]        MAX = {1'b0, {(WIDTH-1){1'b1}}};

    state_t                    state, state_nxt;
    logic [CNTW-1:0]           cnt, cnt_nxt, lim;
    logic                      last, active;
    logic [1:0]                mode_q;
    logic [8:0]                lfsr;
    logic signed [WIDTH-1:0]   run_x;
    logic [WIDTH-1:0]          mag;

    assign active = (state == FLUSH) || (state == RUN) || (state == DRAIN);
    assign busy   = active;
    assign done   = (state == DONE);

    // The most negative code has no positive twin, so clamp it.
    assign mag = !y_in[WIDTH-1] ? $unsigned(y_in) :
                 (y_in == MIN)  ? MAX : $unsigned(-y_in);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lim       = (state == RUN) ? NS_M1 : LEN_M1;
        last      = sam_clk_en && (cnt == lim);
        unique case (state)
            IDLE:    if (start) state_nxt = FLUSH;
            FLUSH:   if (last) state_nxt = RUN;
            RUN:     if (last) state_nxt = DRAIN;
            DRAIN:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (active && sam_clk_en) begin
            cnt_nxt = last ? '0 : cnt + 1'b1;
        end
        if (state == IDLE) begin
            cnt_nxt = '0;
        end
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_comb begin
        run_x = '0;
        unique case (mode_q)
            2'd0: run_x = '0;
            2'd1: if (cnt == '0) run_x = IMP;
            2'd2: begin
                if (sym_clk_en) begin
                    unique case (lfsr[1:0])
                        2'b00: run_x = -A3;
                        2'b01: run_x = -A1;
                        2'b10: run_x = A1;
                        2'b11: run_x = A3;
                    endcase
                end
            end
            2'd3: run_x = A3;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mode_q   <= 2'd0;
            lfsr     <= 9'h1FF;
            x_out    <= '0;
            peak_abs <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && start) begin
                mode_q   <= mode;
                peak_abs <= '0;
                lfsr     <= 9'h1FF;
            end
            if (abort && state != IDLE) begin
                x_out <= '0;
            end else if (sam_clk_en) begin
                x_out <= (state == RUN) ? run_x : '0;
            end
            if (sam_clk_en && (state == RUN || state == DRAIN)
                && mag > peak_abs) begin
                peak_abs <= mag;
            end
            // Advance only after the current symbol has been mapped.
            if (sam_clk_en && sym_clk_en && state == RUN
                && mode_q == 2'd2) begin
                lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
            end
        end
    end

endmodule

// File: tb/tb_filt_stim_seq.sv
// Scoreboard bench for filt_stim_seq: per-strobe expectations from a run-level model.
// A separate monitor pops and compares on every sample strobe.
module tb_filt_stim_seq;

    localparam int L = 93;
    localparam int N = 1024;
    localparam int A = 16384;

    logic               sys_clk = 1'b0;
    logic               rst = 1'b1;
    logic               sam_clk_en = 1'b0;
    logic               sym_clk_en = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic signed [17:0] y_in = '0;
    logic signed [17:0] x_out;
    logic               busy;
    logic               done;
    logic [17:0]        peak_abs;

    filt_stim_seq #(
        .WIDTH(18), .LENGTH(L), .NSAMP(N), .CNTW(11),
        .MAP_A(A), .IMPULSE_AMP(131071)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .sam_clk_en(sam_clk_en),
        .sym_clk_en(sym_clk_en), .start(start), .abort(abort),
        .mode(mode), .y_in(y_in), .x_out(x_out), .busy(busy),
        .done(done), .peak_abs(peak_abs)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int x;
        int busy;
        int done;
        int peak;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errs = 0;
    int   done_seen = 0;
    int   runs_done = 0;

    // model state: ph=1 while a run is active, s = strobes since FLUSH entry
    int   ph = 0;
    int   s = 0;
    int   md = 0;
    int   sym_j = 0;
    int   pk = 0;
    int   nb = 0;
    int   r[0:299];

    task automatic chk(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // PRBS bit stream of x^9+x^5+1 from an all-ones seed
    function automatic int lvl(input int j);
        int idx;
        idx = 2 * r[j+7] + r[j+8];
        return (2 * idx - 3) * A;
    endfunction

    function automatic int absy(input int y);
        if (y == -131072) return 131071;
        return (y < 0) ? -y : y;
    endfunction

    function automatic int gen_y(input int ym);
        int v;
        unique case (ym)
            0: v = (s < L) ? 20000 : $urandom_range(20000) - 10000;
            1: v = (s == L + 5) ? -131072 : $urandom_range(20000) - 10000;
            default: v = int'($urandom_range(262143)) - 131072;
        endcase
        return v;
    endfunction

    always @(posedge sys_clk) begin
        if (done) done_seen++;
    end

    always @(posedge sys_clk) begin
        exp_t e;
        if (sam_clk_en && !rst) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("x_out", int'(x_out), e.x);
                chk("busy", int'(busy), e.busy);
                chk("done", int'(done), e.done);
                chk("peak_abs", int'(peak_abs), e.peak);
            end
        end
    end

    task automatic strobe(input int y);
        exp_t e;
        logic sy;
        int   k;
        sy = (ph == 1) && (s % 4 == 1);
        @(negedge sys_clk);
        if (busy) nb++;
        sam_clk_en = 1'b1;
        sym_clk_en = sy;
        y_in = 18'(y);
        e.x = 0;
        e.done = 0;
        if (ph == 1) begin
            if (s >= L && absy(y) > pk) pk = absy(y);
            if (s >= L && s < L + N) begin
                k = s - L;
                unique case (md)
                    1: e.x = (k == 0) ? 131071 : 0;
                    2: if (sy) begin e.x = lvl(sym_j); sym_j++; end
                    3: e.x = 3 * A;
                    default: e.x = 0;
                endcase
            end
            s++;
            if (s == 2 * L + N) begin
                ph = 0;
                e.done = 1;
            end
        end
        e.busy = ph;
        e.peak = pk;
        exp_q.push_back(e);
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        if (e.done == 1) begin
            runs_done++;
            chk("busy_strobes", nb, 2 * L + N);
            chk("done_in_done_cycle", int'(done), 1);
            @(negedge sys_clk);
            chk("done_one_cycle", int'(done), 0);
        end
        repeat ($urandom_range(2)) @(negedge sys_clk);
    endtask

    task automatic do_start(input logic [1:0] m);
        @(negedge sys_clk);
        start = 1'b1;
        mode = m;
        @(negedge sys_clk);
        start = 1'b0;
        if (ph == 0) begin
            ph = 1; s = 0; md = int'(m); sym_j = 0; pk = 0; nb = 0;
            chk("start_busy", int'(busy), 1);
            chk("start_peak_clr", int'(peak_abs), 0);
        end
    endtask

    task automatic run(input logic [1:0] m, input int ym, input int stop_at);
        do_start(m);
        while (ph == 1 && s != stop_at) strobe(gen_y(ym));
    endtask

    initial begin
        for (int i = 0; i < 9; i++) r[i] = 1;
        for (int i = 9; i < 300; i++) r[i] = r[i-9] ^ r[i-5];

        repeat (3) @(negedge sys_clk);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_peak", int'(peak_abs), 0);
        rst = 1'b0;
        repeat (2) strobe(0);

        run(2'd1, 0, -1);
        run(2'd2, 2, -1);
        run(2'd3, 1, -1);
        chk("peak_saturated", int'(peak_abs), 131071);

        run(2'd0, 2, L + N + 10);
        do_start(2'd3);
        while (ph == 1) strobe(gen_y(2));

        run(2'd3, 2, L + 20);
        @(negedge sys_clk);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        ph = 0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_x_out", int'(x_out), 0);
        chk("abort_peak_held", int'(peak_abs), pk);
        repeat (6) strobe(gen_y(2));

        run(2'd2, 2, L + N + 20);
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        ph = 0;
        pk = 0;
        chk("mrst_x_out", int'(x_out), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_peak", int'(peak_abs), 0);
        rst = 1'b0;
        run(2'd2, 2, L + 40);
        @(negedge sys_clk);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        ph = 0;
        repeat (4) strobe(gen_y(2));

        repeat (4) @(negedge sys_clk);
        chk("done_pulses", done_seen, runs_done);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
